vliw_issue_unit: RTL and testbench
==================================

# vliw_issue_unit

Two-slot VLIW issue and writeback stage that directly feeds the 8-bit functional units (add, sub, mul, and, or, xor). It accepts one 24-bit bundle per cycle over a valid/ready handshake and reads operands from an internal 8×8 register file, forwarding from the bundle in execute. It drives each slot's operands and opcode to the externally instantiated functional units, then writes their 8-bit results back. A bundle containing MUL holds the execute stage for a configurable number of cycles, stalling intake.

## Interface
- MUL_LAT, 2: execute cycles for a bundle containing any MUL; legal range ≥1. Non-MUL bundles always take 1 cycle.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  bundle offered
- in_ready  out  1  bundle accepted on clk edge when in_valid && in_ready
- in_bundle  in  24  slot0 = [11:0], slot1 = [23:12]; each slot is {op[11:9], rd[8:6], rs1[5:3], rs2[2:0]}
- fu_op0, fu_op1  out  3  opcode of the slot in execute; 0 when execute is empty
- fu_a0, fu_b0, fu_a1, fu_b1  out  8  operands of the slot in execute; 0 when execute is empty
- fu_res0, fu_res1  in  8  combinational FU results for each slot
- dbg_addr  in  3  debug register index
- dbg_data  out  8  combinational register-file read of dbg_addr
- retired  out  16  count of bundles written back; wraps at 0xFFFF→0
- wr_conflict  out  1  one-cycle pulse at writeback, both slots target the same rd≠0
- illegal  out  1  one-cycle pulse at writeback, either slot has op=7

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR, 6 XOR, 7 illegal (executes as NOP).
- r0 reads as 0; writes to r0 are dropped. NOP and illegal slots perform no write.
- On accept, both slots read operands, which are registered into the execute stage with valid=1.
- Forwarding: an accepted bundle whose rs matches a writing slot's rd (≠0) in its writeback cycle takes fu_res of that slot, with slot1 taking priority. Otherwise it takes the register-file value.
- Both slots of a bundle see pre-bundle register state, with no intra-bundle forwarding.
- Write conflict: slot1's result wins and wr_conflict pulses.
- Execute FSM states:
  - EMPTY: accept goes to EXEC with cnt=0.
  - EXEC: writeback occurs when the bundle has no MUL or cnt==MUL_LAT-1. Otherwise cnt increments and the state holds.
  - At writeback: if a new bundle is accepted in the same cycle, stay in EXEC with cnt=0; otherwise go to EMPTY.
- in_ready = 1 in EMPTY or in the writeback cycle, and 0 during MUL hold cycles.
- retired increments by 1 at each writeback, including all-NOP bundles.

## Timing
- Bundle accepted at edge N: fu_* are valid during cycle N+1. The register write occurs at edge N+1 for non-MUL bundles and at edge N+MUL_LAT for MUL bundles.
- Back-to-back dependent bundles issue with zero bubbles via forwarding.
- fu_* stay stable for all hold cycles.
- Reset (asynchronous, including mid-MUL hold) clears:
  - all registers to 0
  - the FSM to EMPTY and cnt to 0
  - retired to 0
  - wr_conflict and illegal to 0
  - fu_* to 0
- in_ready is 1 after reset release.
- An in-flight bundle is discarded on reset and not written back.

## Structure
- Package vliw_pkg holds:
  - opcode localparams OP_NOP … OP_ILL
  - SLOT_W=12 and field bit positions
  - NREGS=8, DW=8
- Sub-module vliw_regfile:
  - 8×8 registers
  - 4 operand read ports plus 1 debug read port
  - 2 write ports with slot1 priority
  - r0 hardwired to 0
  - async active-low reset to 0

## Test plan
- Reset, then bundle slot0 ADD r1←r0+r0 and slot1 NOP; fu_res0=0x05 → dbg r1=0x05, retired=1, in_ready never drops.
- r1=5, r2=3. Bundle {SUB r3←r1−r2, XOR r4←r1^r2} → fu_a0=5, fu_b0=3, fu_a1=5, fu_b1=3 in cycle N+1.
- Forwarding:
  - Bundle A: ADD r5 with fu_res0=0x10.
  - Next cycle, bundle B: AND r6←r5&r5.
  - Expect B's fu_a0=fu_b0=0x10 with no bubble.
- MUL_LAT=3, MUL bundle then ADD bundle:
  - in_ready is low for 2 cycles; fu_* are held.
  - Write occurs at the 3rd cycle; ADD is accepted in that same cycle.
- Both slots write r7 (0xAA, 0x55) → r7=0x55, wr_conflict one pulse. Slot0 op=7 → illegal pulse, no write.
- Assert rst_n low during a MUL hold → target register unchanged (0), retired=0, in_ready=1 after release.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared opcodes, bundle field layout and helpers for the two-slot VLIW issue unit.
package vliw_pkg;

  localparam int DW     = 8;
  localparam int NREGS  = 8;
  localparam int RW     = 3;
  localparam int OPW    = 3;
  localparam int SLOT_W = 12;

  localparam int OP_LSB  = 9;
  localparam int RD_LSB  = 6;
  localparam int RS1_LSB = 3;
  localparam int RS2_LSB = 0;

  localparam logic [OPW-1:0] OP_NOP = 3'd0;
  localparam logic [OPW-1:0] OP_ADD = 3'd1;
  localparam logic [OPW-1:0] OP_SUB = 3'd2;
  localparam logic [OPW-1:0] OP_MUL = 3'd3;
  localparam logic [OPW-1:0] OP_AND = 3'd4;
  localparam logic [OPW-1:0] OP_OR  = 3'd5;
  localparam logic [OPW-1:0] OP_XOR = 3'd6;
  localparam logic [OPW-1:0] OP_ILL = 3'd7;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [RW-1:0]  rd;
    logic [RW-1:0]  rs1;
    logic [RW-1:0]  rs2;
  } slot_t;

  typedef enum logic {ST_EMPTY, ST_EXEC} state_t;

  // NOP and illegal slots never touch the register file.
  function automatic logic op_writes(input logic [OPW-1:0] op);
    return (op != OP_NOP) && (op != OP_ILL);
  endfunction

endpackage

// File: rtl/vliw_regfile.sv
// 8x8 register file: four operand read ports, one debug read port, two write ports.
module vliw_regfile
  import vliw_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] raddr [4],
  output logic [DW-1:0] rdata [4],
  input  logic          we0,
  input  logic [RW-1:0] waddr0,
  input  logic [DW-1:0] wdata0,
  input  logic          we1,
  input  logic [RW-1:0] waddr1,
  input  logic [DW-1:0] wdata1,
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      // r0 never leaves reset value; slot1 wins a same-register collision.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs[gi] <= '0;
        end else if (gi != 0) begin
          if (we1 && (waddr1 == RW'(gi)))
            regs[gi] <= wdata1;
          else if (we0 && (waddr0 == RW'(gi)))
            regs[gi] <= wdata0;
        end
      end
    end

    for (gi = 0; gi < 4; gi++) begin : g_rd
      assign rdata[gi] = regs[raddr[gi]];
    end
  endgenerate

  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/vliw_issue_unit.sv
// Two-slot VLIW issue/writeback stage: operand read with forwarding, MUL hold, writeback.
module vliw_issue_unit
  import vliw_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [23:0]   in_bundle,
  output logic [2:0]    fu_op0,
  output logic [2:0]    fu_op1,
  output logic [7:0]    fu_a0,
  output logic [7:0]    fu_b0,
  output logic [7:0]    fu_a1,
  output logic [7:0]    fu_b1,
  input  logic [7:0]    fu_res0,
  input  logic [7:0]    fu_res1,
  input  logic [2:0]    dbg_addr,
  output logic [7:0]    dbg_data,
  output logic [15:0]   retired,
  output logic          wr_conflict,
  output logic          illegal
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [OPW-1:0]  ex_op_reg [2];
  logic [RW-1:0]   ex_rd_reg [2];
  logic [DW-1:0]   ex_a_reg  [2];
  logic [DW-1:0]   ex_b_reg  [2];
  logic            ex_mul_reg;
  logic [15:0]     retired_reg;

  slot_t           in_slot [2];
  logic [DW-1:0]   res     [2];
  logic            we      [2];
  logic [RW-1:0]   raddr   [4];
  logic [DW-1:0]   rf_data [4];
  logic [DW-1:0]   opnd    [4];
  logic            wb, accept, in_mul, exec;

  assign in_slot[0] = slot_t'(in_bundle[SLOT_W-1:0]);
  assign in_slot[1] = slot_t'(in_bundle[2*SLOT_W-1:SLOT_W]);
  assign res[0]     = fu_res0;
  assign res[1]     = fu_res1;

  assign exec     = (state_reg == ST_EXEC);
  assign wb       = exec && (!ex_mul_reg || (cnt_reg == CW'(MUL_LAT - 1)));
  assign in_ready = (state_reg == ST_EMPTY) || wb;
  assign accept   = in_valid && in_ready;
  assign in_mul   = (in_slot[0].op == OP_MUL) || (in_slot[1].op == OP_MUL);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign we[gi]          = wb && op_writes(ex_op_reg[gi]) && (ex_rd_reg[gi] != '0);
      assign raddr[2*gi]     = in_slot[gi].rs1;
      assign raddr[2*gi + 1] = in_slot[gi].rs2;
    end

    // Bypass the retiring results so the next bundle sees post-writeback state.
    for (gi = 0; gi < 4; gi++) begin : g_fwd
      always_comb begin
        opnd[gi] = rf_data[gi];
        if (we[0] && (ex_rd_reg[0] == raddr[gi])) opnd[gi] = res[0];
        if (we[1] && (ex_rd_reg[1] == raddr[gi])) opnd[gi] = res[1];
      end
    end
  endgenerate

  vliw_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr    (raddr),
    .rdata    (rf_data),
    .we0      (we[0]),
    .waddr0   (ex_rd_reg[0]),
    .wdata0   (res[0]),
    .we1      (we[1]),
    .waddr1   (ex_rd_reg[1]),
    .wdata1   (res[1]),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_EXEC;
          cnt_next   = '0;
        end
      end
      ST_EXEC: begin
        if (wb) begin
          cnt_next = '0;
          if (!accept) state_next = ST_EMPTY;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = ST_EMPTY;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_EMPTY;
      cnt_reg     <= '0;
      retired_reg <= '0;
      ex_mul_reg  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ex_op_reg[i] <= '0;
        ex_rd_reg[i] <= '0;
        ex_a_reg[i]  <= '0;
        ex_b_reg[i]  <= '0;
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (wb) retired_reg <= retired_reg + 16'd1;
      if (accept) begin
        ex_mul_reg <= in_mul;
        for (int i = 0; i < 2; i++) begin
          ex_op_reg[i] <= in_slot[i].op;
          ex_rd_reg[i] <= in_slot[i].rd;
          ex_a_reg[i]  <= opnd[2*i];
          ex_b_reg[i]  <= opnd[2*i + 1];
        end
      end
    end
  end

  assign fu_op0 = exec ? ex_op_reg[0] : '0;
  assign fu_op1 = exec ? ex_op_reg[1] : '0;
  assign fu_a0  = exec ? ex_a_reg[0]  : '0;
  assign fu_b0  = exec ? ex_b_reg[0]  : '0;
  assign fu_a1  = exec ? ex_a_reg[1]  : '0;
  assign fu_b1  = exec ? ex_b_reg[1]  : '0;

  assign retired     = retired_reg;
  assign wr_conflict = we[0] && we[1] && (ex_rd_reg[0] == ex_rd_reg[1]);
  assign illegal     = wb && ((ex_op_reg[0] == OP_ILL) || (ex_op_reg[1] == OP_ILL));

endmodule

// File: tb/tb_vliw_issue_unit.sv
// Bench for vliw_issue_unit: directed vector table, reset-during-hold sequence, random vs model.
module tb_vliw_issue_unit;
  import vliw_pkg::*;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_bundle = '0;
  logic [2:0]  fu_op0, fu_op1;
  logic [7:0]  fu_a0, fu_b0, fu_a1, fu_b1;
  logic [7:0]  fu_res0 = '0, fu_res1 = '0;
  logic [2:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;
  logic [15:0] retired;
  logic        wr_conflict, illegal;

  always #5 clk = ~clk;

  vliw_issue_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bundle(in_bundle), .fu_op0(fu_op0), .fu_op1(fu_op1),
    .fu_a0(fu_a0), .fu_b0(fu_b0), .fu_a1(fu_a1), .fu_b1(fu_b1),
    .fu_res0(fu_res0), .fu_res1(fu_res1), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .retired(retired), .wr_conflict(wr_conflict),
    .illegal(illegal)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Bundle-level reference: a bundle occupies execute for 1 or MUL_LAT cycles,
  // and a newly accepted bundle reads the register state after the retiring one.
  logic [7:0]  m_regs [8];
  bit          m_busy;
  int          m_rem;
  logic [2:0]  m_op [2];
  logic [2:0]  m_rd [2];
  logic [7:0]  m_a [2];
  logic [7:0]  m_b [2];
  logic [15:0] m_ret;

  function automatic bit writes(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd6);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_busy = 0;
    m_rem  = 0;
    m_ret  = '0;
    for (int s = 0; s < 2; s++) begin
      m_op[s] = '0; m_rd[s] = '0; m_a[s] = '0; m_b[s] = '0;
    end
  endtask

  task automatic drive(input bit v, input logic [23:0] b, input logic [7:0] r0,
                       input logic [7:0] r1, input logic [2:0] da);
    in_valid  = v;
    in_bundle = b;
    fu_res0   = r0;
    fu_res1   = r1;
    dbg_addr  = da;
    #1;
  endtask

  task automatic tick(input string tag);
    bit wb, rdy, mul;
    logic [11:0] sl;
    logic [7:0] res [2];
    wb  = m_busy && (m_rem == 1);
    rdy = !m_busy || wb;
    chk({tag, " in_ready"}, in_ready, rdy);
    chk({tag, " fu_op0"}, fu_op0, m_busy ? m_op[0] : 3'd0);
    chk({tag, " fu_op1"}, fu_op1, m_busy ? m_op[1] : 3'd0);
    chk({tag, " fu_a0"}, fu_a0, m_busy ? m_a[0] : 8'd0);
    chk({tag, " fu_b0"}, fu_b0, m_busy ? m_b[0] : 8'd0);
    chk({tag, " fu_a1"}, fu_a1, m_busy ? m_a[1] : 8'd0);
    chk({tag, " fu_b1"}, fu_b1, m_busy ? m_b[1] : 8'd0);
    chk({tag, " wr_conflict"}, wr_conflict,
        wb && writes(m_op[0]) && writes(m_op[1]) && m_rd[0] == m_rd[1] && m_rd[0] != 0);
    chk({tag, " illegal"}, illegal, wb && (m_op[0] == 3'd7 || m_op[1] == 3'd7));
    chk({tag, " retired"}, retired, m_ret);
    chk({tag, " dbg_data"}, dbg_data, m_regs[dbg_addr]);
    res[0] = fu_res0;
    res[1] = fu_res1;
    if (wb) begin
      for (int s = 0; s < 2; s++)
        if (writes(m_op[s]) && m_rd[s] != 0) m_regs[m_rd[s]] = res[s];
      m_ret  = m_ret + 16'd1;
      m_busy = 0;
    end else if (m_busy) begin
      m_rem--;
    end
    if (in_valid && rdy) begin
      mul = 0;
      for (int s = 0; s < 2; s++) begin
        sl      = in_bundle[12*s +: 12];
        m_op[s] = sl[11:9];
        m_rd[s] = sl[8:6];
        m_a[s]  = (sl[5:3] == 0) ? 8'd0 : m_regs[sl[5:3]];
        m_b[s]  = (sl[2:0] == 0) ? 8'd0 : m_regs[sl[2:0]];
        if (sl[11:9] == 3'd3) mul = 1;
      end
      m_busy = 1;
      m_rem  = mul ? MUL_LAT : 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] S(input int op, input int rd, input int rs1, input int rs2);
    return {op[2:0], rd[2:0], rs1[2:0], rs2[2:0]};
  endfunction

  function automatic logic [23:0] B(input logic [11:0] s1, input logic [11:0] s0);
    return {s1, s0};
  endfunction

  typedef struct {
    bit          v;
    logic [23:0] b;
    logic [7:0]  r0, r1;
    logic [2:0]  da;
    bit          rdy;
    logic [2:0]  op0;
    logic [7:0]  a0, b0;
    logic [2:0]  op1;
    logic [7:0]  a1, b1;
    bit          conf, ill;
    logic [7:0]  dbg;
    logic [15:0] ret;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] nop;
    nop = '0;
    //            v  bundle                               r0     r1     da rdy op0 a0     b0    op1 a1 b1 cf il dbg    ret
    tbl[0]  = '{1, B(nop, S(1,1,0,0)),              8'h00, 8'h00, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0};
    tbl[1]  = '{0, 24'h0,                           8'h05, 8'h00, 1, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0};
    tbl[2]  = '{1, B(nop, S(1,2,0,0)),              8'h00, 8'h00, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h05, 1};
    tbl[3]  = '{1, B(S(6,4,1,2), S(2,3,1,2)),       8'h03, 8'h00, 1, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h05, 1};
    tbl[4]  = '{1, B(nop, S(1,5,0,0)),              8'h02, 8'h06, 2, 1, 2, 8'h05, 8'h03, 6, 5, 3, 0, 0, 8'h03, 2};
    tbl[5]  = '{1, B(nop, S(4,6,5,5)),              8'h10, 8'h00, 3, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h02, 3};
    tbl[6]  = '{1, B(nop, S(3,5,3,4)),              8'h10, 8'h00, 4, 1, 4, 8'h10, 8'h10, 0, 0, 0, 0, 0, 8'h06, 4};
    tbl[7]  = '{1, B(nop, S(1,6,5,1)),              8'h0C, 8'h00, 6, 0, 3, 8'h02, 8'h06, 0, 0, 0, 0, 0, 8'h10, 5};
    tbl[8]  = '{1, B(nop, S(1,6,5,1)),              8'h0C, 8'h00, 6, 0, 3, 8'h02, 8'h06, 0, 0, 0, 0, 0, 8'h10, 5};
    tbl[9]  = '{1, B(nop, S(1,6,5,1)),              8'h0C, 8'h00, 5, 1, 3, 8'h02, 8'h06, 0, 0, 0, 0, 0, 8'h10, 5};
    tbl[10] = '{1, B(S(1,7,0,0), S(1,7,0,0)),       8'h11, 8'h00, 5, 1, 1, 8'h0C, 8'h05, 0, 0, 0, 0, 0, 8'h0C, 6};
    tbl[11] = '{1, B(nop, S(7,2,1,1)),              8'hAA, 8'h55, 6, 1, 1, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h11, 7};
    tbl[12] = '{0, 24'h0,                           8'h99, 8'h00, 7, 1, 7, 8'h05, 8'h05, 0, 0, 0, 0, 1, 8'h55, 8};
    tbl[13] = '{0, 24'h0,                           8'h00, 8'h00, 2, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h03, 9};

    model_reset();
    #12;
    chk("reset in_ready", in_ready, 1);
    chk("reset fu_op0", fu_op0, 0);
    chk("reset fu_a1", fu_a1, 0);
    chk("reset retired", retired, 0);
    chk("reset flags", {wr_conflict, illegal}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].b, tbl[i].r0, tbl[i].r1, tbl[i].da);
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("vec%0d fu_op0/op1", i), {fu_op0, fu_op1}, {tbl[i].op0, tbl[i].op1});
      chk($sformatf("vec%0d fu_a0/b0", i), {fu_a0, fu_b0}, {tbl[i].a0, tbl[i].b0});
      chk($sformatf("vec%0d fu_a1/b1", i), {fu_a1, fu_b1}, {tbl[i].a1, tbl[i].b1});
      chk($sformatf("vec%0d wr_conflict", i), wr_conflict, tbl[i].conf);
      chk($sformatf("vec%0d illegal", i), illegal, tbl[i].ill);
      chk($sformatf("vec%0d dbg_data", i), dbg_data, tbl[i].dbg);
      chk($sformatf("vec%0d retired", i), retired, tbl[i].ret);
      $display("vec%0d: valid=%0d bundle=%06h ready=%0d op0=%0d a0=%02h b0=%02h op1=%0d a1=%02h b1=%02h dbg=%02h ret=%0d",
               i, tbl[i].v, tbl[i].b, in_ready, fu_op0, fu_a0, fu_b0, fu_op1, fu_a1, fu_b1, dbg_data, retired);
      tick($sformatf("vec%0d model", i));
    end

    // Reset asserted in the middle of a MUL hold discards the in-flight bundle.
    drive(1, B(nop, S(3,3,1,1)), 8'h00, 8'h00, 3);
    tick("rst accept");
    drive(0, 24'h0, 8'h19, 8'h00, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_hold in_ready", in_ready, 1);
    chk("rst_hold fu_op0", fu_op0, 0);
    chk("rst_hold fu_a0", fu_a0, 0);
    chk("rst_hold retired", retired, 0);
    chk("rst_hold dbg r1", dbg_data, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 24'h0, 8'h19, 8'h00, 3);
      $display("post-reset cycle %0d: ready=%0d dbg r3=%02h ret=%0d", i, in_ready, dbg_data, retired);
      tick($sformatf("post_rst%0d", i));
    end

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 24'($urandom), 8'($urandom), 8'($urandom),
            3'($urandom_range(0, 7)));
      $display("rand%0d: valid=%0d bundle=%06h ready=%0d op0=%0d op1=%0d ret=%0d",
               i, in_valid, in_bundle, in_ready, fu_op0, fu_op1, retired);
      tick($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
